// File: rtl/csa_sched_pkg.sv
// ============================================================================
// Module : csa_sched_pkg
// Brief  : Shared types and defaults for the two-pass 64-bit add scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package csa_sched_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_SLICE = 32;
  localparam int REQ_ID_W  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rca_slice_add.sv
// ============================================================================
// Module : rca_slice_add
// Brief  : SLICE-bit combinational ripple-carry adder shared by both passes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rca_slice_add #(
  parameter int SLICE = 32
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_c0,
  output logic [SLICE-1:0] o_s,
  output logic             o_c_out
);

  logic [SLICE:0] w_c;

  assign w_c[0] = i_c0;

  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    assign o_s[i]     = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_c_out = w_c[SLICE];

endmodule

`default_nettype wire

// File: rtl/csa_add_scheduler.sv
// ============================================================================
// Module : csa_add_scheduler
// Brief  : Two requesters share one SLICE-bit adder; each 64-bit add runs as a
//          low pass then a high pass. Optional signed overflow: ADD_OVF_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_add_scheduler
  import csa_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [WIDTH-1:0]    req0_a,
  input  logic [WIDTH-1:0]    req0_b,
  input  logic                req0_c0,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [WIDTH-1:0]    req1_a,
  input  logic [WIDTH-1:0]    req1_b,
  input  logic                req1_c0,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [REQ_ID_W-1:0] rsp_id,
  output logic [WIDTH-1:0]    s,
  output logic                c_out
`ifdef ADD_OVF_EN
  ,
  output logic                ovf
`endif
);

  state_t              r_state;
  state_t              w_next;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic                r_c0;
  logic [REQ_ID_W-1:0] r_id;
  logic [REQ_ID_W-1:0] r_last_grant;
  logic                r_c_lo;
  logic                r_rsp_valid;
  logic [REQ_ID_W-1:0] r_rsp_id;
  logic [WIDTH-1:0]    r_s;
  logic                r_c_out;

  logic                w_grant_en;
  logic [REQ_ID_W-1:0] w_gnt_id;
  logic                w_accept;
  logic [SLICE-1:0]    w_sl_a;
  logic [SLICE-1:0]    w_sl_b;
  logic                w_sl_c0;
  logic [SLICE-1:0]    w_sl_s;
  logic                w_sl_c;

  // rst_n gates the grant so neither requester sees READY while in reset.
  assign w_grant_en = rst_n & ((r_state == IDLE) | ((r_state == DONE) & rsp_ready));
  assign w_gnt_id   = (req0_valid && req1_valid) ? ~r_last_grant : REQ_ID_W'(req1_valid);
  assign req0_ready = w_grant_en & req0_valid & (w_gnt_id == '0);
  assign req1_ready = w_grant_en & req1_valid & (w_gnt_id != '0);
  assign w_accept   = req0_ready | req1_ready;

  assign w_sl_a  = (r_state == HI) ? r_a[WIDTH-1:SLICE] : r_a[SLICE-1:0];
  assign w_sl_b  = (r_state == HI) ? r_b[WIDTH-1:SLICE] : r_b[SLICE-1:0];
  assign w_sl_c0 = (r_state == HI) ? r_c_lo : r_c0;

  rca_slice_add #(
    .SLICE (SLICE)
  ) u_slice (
    .i_a     (w_sl_a),
    .i_b     (w_sl_b),
    .i_c0    (w_sl_c0),
    .o_s     (w_sl_s),
    .o_c_out (w_sl_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = LO;
      LO:      w_next = HI;
      HI:      w_next = DONE;
      DONE:    if (rsp_ready) w_next = w_accept ? LO : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_c0         <= 1'b0;
      r_id         <= '0;
      r_last_grant <= REQ_ID_W'(1);
      r_c_lo       <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_s          <= '0;
      r_c_out      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a          <= (w_gnt_id != '0) ? req1_a  : req0_a;
        r_b          <= (w_gnt_id != '0) ? req1_b  : req0_b;
        r_c0         <= (w_gnt_id != '0) ? req1_c0 : req0_c0;
        r_id         <= w_gnt_id;
        r_last_grant <= w_gnt_id;
      end
      case (r_state)
        LO: begin
          r_s[SLICE-1:0] <= w_sl_s;
          r_c_lo         <= w_sl_c;
        end
        HI: begin
          r_s[WIDTH-1:SLICE] <= w_sl_s;
          r_c_out            <= w_sl_c;
          r_rsp_valid        <= 1'b1;
          r_rsp_id           <= r_id;
        end
        DONE: if (rsp_ready) r_rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef ADD_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ovf <= 1'b0;
    else if (r_state == HI)
      r_ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sl_s[SLICE-1] != r_a[WIDTH-1]);
  end

  assign ovf = r_ovf;
`endif

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign s         = r_s;
  assign c_out     = r_c_out;

endmodule

`default_nettype wire
